bloom_sig_gen: RTL and testbench

Request-side front end for the bloom filter. Accepts raw keys over a valid/ready handshake and computes K hash indices serially, one per cycle, folding them into a SIZE-bit one-hot-OR signature. Drives the filter's `data`/`insert`/`check` inputs as a two-cycle command and, for check operations, samples the filter's `match` back into a registered hit result. It is the initiator counterpart that feeds the filter its pre-encoded patterns.

---
 rtl/bloom_pkg.sv | 18 +
 rtl/bloom_hash_fold.sv | 32 +++
 rtl/bloom_sig_gen.sv | 112 +++++++++++
 tb/tb_bloom_sig_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bloom_pkg.sv
// Shared types and constants for the bloom filter request front end.
package bloom_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HASH,
        ISSUE,
        RESP
    } state_t;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_CHECK  = 1'b1;

    localparam int unsigned ROT_STEP = 5;
    // K is at most 8, so the hash counter never needs more than 3 bits.
    localparam int unsigned J_W = 3;

endpackage

// File: rtl/bloom_hash_fold.sv
// Combinational hash h_j: rotate the key left by (ROT_STEP*j) mod KEY_W,
// then XOR-fold it into IDX_W-bit chunks, with the top chunk zero-padded.
module bloom_hash_fold
    import bloom_pkg::*;
#(
    parameter int unsigned KEY_W = 16,
    parameter int unsigned IDX_W = 3
) (
    input  logic [KEY_W-1:0] key,
    input  logic [J_W-1:0]   j,
    output logic [IDX_W-1:0] h
);

    localparam int unsigned NCH = (KEY_W + IDX_W - 1) / IDX_W;

    int unsigned            amt;
    logic [KEY_W-1:0]       rot;
    logic [NCH*IDX_W-1:0]   padded;

    always_comb begin
        amt    = (ROT_STEP * 32'(j)) % KEY_W;
        // Shifting right by the full KEY_W yields zero, which covers amt == 0.
        rot    = (key << amt) | (key >> (KEY_W - amt));
        padded = '0;
        padded[KEY_W-1:0] = rot;
        h      = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            h = h ^ padded[c*IDX_W +: IDX_W];
        end
    end

endmodule

// File: rtl/bloom_sig_gen.sv
// Bloom filter request front end: serial K-hash signature build, then a
// two-cycle insert/check command. Optional feature: BLOOM_SIG_CNT_EN adds ins_cnt.
module bloom_sig_gen
    import bloom_pkg::*;
#(
    parameter int unsigned KEY_W = 16,
    parameter int unsigned SIZE  = 8,
    parameter int unsigned K     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [KEY_W-1:0] key_in,
    input  logic             op_in,
    output logic [SIZE-1:0]  sig_out,
    output logic             insert,
    output logic             check,
    input  logic             match_in,
    output logic             done,
    output logic             hit_out
`ifdef BLOOM_SIG_CNT_EN
    ,
    output logic [15:0]      ins_cnt
`endif
);

    localparam int unsigned     IDX_W  = $clog2(SIZE);
    localparam logic [J_W-1:0]  J_LAST = J_W'(K - 1);

    state_t             state, next_state;
    logic [J_W-1:0]     j;
    logic [KEY_W-1:0]   key_q;
    logic               op_q;
    logic [IDX_W-1:0]   h;
    logic               accept;

    assign accept = req_valid & req_ready;

    bloom_hash_fold #(
        .KEY_W (KEY_W),
        .IDX_W (IDX_W)
    ) u_fold (
        .key (key_q),
        .j   (j),
        .h   (h)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)      next_state = HASH;
            HASH:    if (j == J_LAST) next_state = ISSUE;
            ISSUE:   if (j == 3'd1)   next_state = RESP;
            RESP:                     next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    // Strobes and ready are registered from next_state so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            j         <= '0;
            key_q     <= '0;
            op_q      <= OP_INSERT;
            sig_out   <= '0;
            req_ready <= 1'b0;
            insert    <= 1'b0;
            check     <= 1'b0;
            done      <= 1'b0;
            hit_out   <= 1'b0;
        end else begin
            state     <= next_state;
            req_ready <= (next_state == IDLE);
            insert    <= (next_state == ISSUE) && (op_q == OP_INSERT);
            check     <= (next_state == ISSUE) && (op_q == OP_CHECK);
            done      <= (next_state == RESP);
            if (next_state == RESP && op_q == OP_CHECK) begin
                hit_out <= match_in;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        key_q   <= key_in;
                        op_q    <= op_in;
                        sig_out <= '0;
                        j       <= '0;
                    end
                end
                HASH: begin
                    sig_out <= sig_out | ({{(SIZE-1){1'b0}}, 1'b1} << h);
                    j       <= (j == J_LAST) ? '0 : j + 1'b1;
                end
                // j is reused to count the two ISSUE cycles.
                ISSUE:   j <= j + 1'b1;
                default: j <= '0;
            endcase
        end
    end

`ifdef BLOOM_SIG_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_cnt <= '0;
        end else if (next_state == RESP && op_q == OP_INSERT && ins_cnt != 16'hFFFF) begin
            ins_cnt <= ins_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bloom_sig_gen.sv
// Directed bench for bloom_sig_gen (KEY_W=16, SIZE=8, K=3).
module tb_bloom_sig_gen;

    localparam int K = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] key_in;
    logic        op_in;
    logic [7:0]  sig_out;
    logic        insert;
    logic        check;
    logic        match_in;
    logic        done;
    logic        hit_out;
`ifdef BLOOM_SIG_CNT_EN
    logic [15:0] ins_cnt;
`endif

    int nvec = 0;
    int nerr = 0;
    logic hit_exp;

    typedef struct {
        logic [15:0] key;
        logic        op;
        logic        m;
        logic [7:0]  sig;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    bloom_sig_gen #(
        .KEY_W (16),
        .SIZE  (8),
        .K     (K)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .key_in    (key_in),
        .op_in     (op_in),
        .sig_out   (sig_out),
        .insert    (insert),
        .check     (check),
        .match_in  (match_in),
        .done      (done),
        .hit_out   (hit_out)
`ifdef BLOOM_SIG_CNT_EN
        ,
        .ins_cnt   (ins_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready;
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // One full request with cycle-by-cycle checks; cycle c follows edge c-1.
    task automatic run_op(input logic [15:0] key, input logic op, input logic m,
                          input logic [7:0] sig);
        wait_ready();
        req_valid = 1'b1;
        key_in    = key;
        op_in     = op;
        match_in  = ~m;
        tick();
        req_valid = 1'b0;
        key_in    = ~key;
        op_in     = ~op;
        if (op) hit_exp = m;
        for (int c = 1; c <= K + 3; c++) begin
            if (c >= K + 2) match_in = m;
            chk("busy_ready", 32'(req_ready), 32'd0);
            chk("insert", 32'(insert), 32'((c == K + 1 || c == K + 2) && !op));
            chk("check", 32'(check), 32'((c == K + 1 || c == K + 2) && op));
            chk("done", 32'(done), 32'(c == K + 3));
            if (c >= K + 1) chk("sig_out", 32'(sig_out), 32'(sig));
            if (c == K + 3) chk("hit_out", 32'(hit_out), 32'(hit_exp));
            tick();
        end
        match_in = 1'b0;
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_sig", 32'(sig_out), 32'(sig));
    endtask

    initial begin
        vecs[0] = '{key: 16'h0001, op: 1'b0, m: 1'b0, sig: 8'h16};
        vecs[1] = '{key: 16'h0000, op: 1'b0, m: 1'b0, sig: 8'h01};
        vecs[2] = '{key: 16'h0001, op: 1'b1, m: 1'b1, sig: 8'h16};
        vecs[3] = '{key: 16'h00FF, op: 1'b0, m: 1'b0, sig: 8'h28};
        vecs[4] = '{key: 16'h0001, op: 1'b1, m: 1'b0, sig: 8'h16};
        vecs[5] = '{key: 16'h00FF, op: 1'b1, m: 1'b1, sig: 8'h28};
        vecs[6] = '{key: 16'h8000, op: 1'b0, m: 1'b1, sig: 8'h06};

        rst       = 1'b1;
        req_valid = 1'b0;
        key_in    = '0;
        op_in     = 1'b0;
        match_in  = 1'b0;
        hit_exp   = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_sig", 32'(sig_out), 32'd0);
        chk("rst_strobes", {30'd0, insert, check}, 32'd0);
        chk("rst_done_hit", {30'd0, done, hit_out}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].key, vecs[i].op, vecs[i].m, vecs[i].sig);
        end

        // Back-to-back: req_valid held, key changed during HASH.
        wait_ready();
        req_valid = 1'b1;
        key_in    = 16'h0001;
        op_in     = 1'b0;
        tick();
        tick();
        key_in = 16'h8000;
        for (int c = 2; c <= 7; c++) begin
            if (c == K + 1) chk("b2b_sig1", 32'(sig_out), 32'h16);
            if (c == K + 3) chk("b2b_done1", 32'(done), 32'd1);
            if (c == K + 4) chk("b2b_ready", 32'(req_ready), 32'd1);
            else chk("b2b_busy", 32'(req_ready), 32'd0);
            tick();
        end
        chk("b2b_accept2", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("b2b_sig2", 32'(sig_out), 32'h06);
        chk("b2b_ins2", 32'(insert), 32'd1);
        begin
            int n = 0;
            while (done !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("b2b_done2", 32'(done), 32'd1);
        end
        tick();

        // Reset asserted in cycle 2 of HASH.
        wait_ready();
        req_valid = 1'b1;
        key_in    = 16'h0001;
        op_in     = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_sig", 32'(sig_out), 32'd0);
        chk("mid_rst_hit", 32'(hit_out), 32'd0);
        hit_exp = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_ready_after", 32'(req_ready), 32'd1);
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                seen = seen | insert | done | check;
                tick();
            end
            chk("mid_rst_no_cmd", 32'(seen), 32'd0);
        end

`ifdef BLOOM_SIG_CNT_EN
        run_op(16'h0001, 1'b0, 1'b0, 8'h16);
        run_op(16'h0001, 1'b1, 1'b1, 8'h16);
        run_op(16'h0000, 1'b0, 1'b0, 8'h01);
        run_op(16'h00FF, 1'b1, 1'b0, 8'h28);
        run_op(16'h8000, 1'b0, 1'b0, 8'h06);
        chk("ins_cnt_3", 32'(ins_cnt), 32'd3);
        force dut.ins_cnt = 16'hFFFF;
        tick();
        release dut.ins_cnt;
        run_op(16'h0001, 1'b0, 1'b0, 8'h16);
        chk("ins_cnt_sat", 32'(ins_cnt), 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
